// File: rtl/seg7_scan_disp_pkg.sv
// Shared constants for the seven-segment display stages: hex glyph table
// and the all-dark anode/segment patterns.
package seg7_scan_disp_pkg;

    typedef logic [2:0] digit_idx_t;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_scan_disp_hex2seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex2seg7
    import seg7_scan_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_disp.sv
// Eight-digit multiplexed common-anode display driver with per-frame word
// snapshot, per-digit blink and decimal-point control.
module seg7_scan_disp
    import seg7_scan_disp_pkg::*;
#(
    parameter int SCAN_DIV_W  = 17,
    parameter int BLINK_DIV_W = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] hexs,
    input  logic [7:0]  point,
    input  logic [7:0]  blink,
    input  logic        en,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT
);

    localparam logic [SCAN_DIV_W-1:0]  PRESC_ONE = 1;
    localparam logic [BLINK_DIV_W-1:0] BLINK_ONE = 1;

    logic [SCAN_DIV_W-1:0]  presc_q, presc_d;
    logic [BLINK_DIV_W-1:0] blink_cnt_q, blink_cnt_d;
    digit_idx_t             idx_q, idx_d;
    logic                   phase_q, phase_d;
    logic [31:0]            snap_q, snap_d;
    logic [7:0]             an_q, an_d;
    logic [7:0]             seg_q, seg_d;

    logic                   tick;
    logic                   lit;
    logic [3:0]             nibble;
    logic [6:0]             glyph_n;

    hex2seg7 u_dec (
        .nibble (nibble),
        .seg_n  (glyph_n)
    );

    always_comb begin
        tick        = &presc_q;
        presc_d     = presc_q + PRESC_ONE;
        idx_d       = tick ? idx_q + 3'd1 : idx_q;
        // Latch the word only as the last digit ends so a frame never tears.
        snap_d      = (tick && idx_q == 3'd7) ? hexs : snap_q;
        blink_cnt_d = blink_cnt_q + BLINK_ONE;
        phase_d     = (&blink_cnt_q) ? ~phase_q : phase_q;

        nibble      = snap_q[{idx_q, 2'b00} +: 4];
        lit         = en & ~(blink[idx_q] & phase_q);
        an_d        = lit ? ~(8'b1 << idx_q) : AN_OFF;
        seg_d       = lit ? {~point[idx_q], glyph_n} : SEG_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q     <= '0;
            blink_cnt_q <= '0;
            idx_q       <= '0;
            phase_q     <= 1'b0;
            snap_q      <= '0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
        end else begin
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            idx_q       <= idx_d;
            phase_q     <= phase_d;
            snap_q      <= snap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign AN      = an_q;
    assign SEGMENT = seg_q;

endmodule

// File: tb/tb_seg7_scan_disp.sv
// Self-checking bench for seg7_scan_disp: directed scenarios plus random
// traffic compared against a cycle-count based reference model.
module tb_seg7_scan_disp;

    localparam int SDW   = 2;
    localparam int BDW   = 5;
    localparam int SLOT  = 1 << SDW;
    localparam int FRAME = 8 * SLOT;
    localparam int BLINK_HALF = 1 << BDW;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hexs;
    logic [7:0]  point, blink;
    logic        en;
    logic [7:0]  an, seg;

    int checks = 0;
    int errors = 0;
    int e = 0;

    seg7_scan_disp #(.SCAN_DIV_W(SDW), .BLINK_DIV_W(BDW)) dut (
        .clk     (clk),
        .rst     (rst),
        .hexs    (hexs),
        .point   (point),
        .blink   (blink),
        .en      (en),
        .AN      (an),
        .SEGMENT (seg)
    );

    always #5 clk = ~clk;

    // Reference model: everything derives from the number of clocks since reset.
    logic [6:0] ref_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          mcyc = 0;
    logic [31:0] msnap = '0;
    logic [7:0]  exp_an = 8'hFF;
    logic [7:0]  exp_seg = 8'hFF;

    always @(posedge clk) begin
        int  d;
        bit  ph, lt;
        if (rst) begin
            mcyc    = 0;
            msnap   = '0;
            exp_an  = 8'hFF;
            exp_seg = 8'hFF;
        end else begin
            d  = (mcyc / SLOT) % 8;
            ph = ((mcyc / BLINK_HALF) % 2) == 1;
            lt = en && !(blink[d] && ph);
            exp_an  = lt ? ~(8'b1 << d) : 8'hFF;
            exp_seg = lt ? {~point[d], ref_tbl[(msnap >> (4 * d)) & 32'hF]} : 8'hFF;
            if ((mcyc + 1) % FRAME == 0) msnap = hexs;
            mcyc++;
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (e=%0d)", tag, got, want, e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        e++;
        chk("model_an", an, exp_an);
        chk("model_seg", seg, exp_seg);
        checks++;
        assert ($countones(~an) <= 1) else begin
            errors++;
            $error("FAIL onehot_an: observed %h expected at most one low bit", an);
        end
    endtask

    task automatic run_to(input int target);
        while (e < target) step();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; hexs = '0; point = '0; blink = '0;
        repeat (3) @(negedge clk);
        chk("reset_an", an, 8'hFF);
        chk("reset_seg", seg, 8'hFF);

        // 1: first frame shows the zero snapshot, second frame the word
        rst = 1'b0; en = 1'b1; hexs = 32'h8765_4321; e = 0;
        run_to(1);   chk("f0_an0", an, 8'hFE); chk("f0_seg0", seg, 8'hC0);
        run_to(4);   chk("f0_hold_an", an, 8'hFE);
        run_to(5);   chk("f0_an1", an, 8'hFD);
        run_to(33);  chk("f1_an0", an, 8'hFE); chk("f1_seg0", seg, 8'hF9);

        // 2: word change mid-frame stays invisible until the next frame
        run_to(45);  hexs = 32'hFFFF_FFFF;
        run_to(49);  chk("tear_an4", an, 8'hEF); chk("tear_seg4", seg, 8'h92);
        run_to(61);  chk("f1_an7", an, 8'h7F); chk("f1_seg7", seg, 8'h80);
        run_to(65);  chk("f2_an0", an, 8'hFE); chk("f2_seg0", seg, 8'h8E);
        run_to(93);  chk("f2_seg7", seg, 8'h8E);

        // 3: blink digit 0
        run_to(96);  blink = 8'h01; hexs = 32'h0;
        run_to(97);  chk("blk_off_an", an, 8'hFF); chk("blk_off_seg", seg, 8'hFF);
        run_to(101); chk("blk_other_an", an, 8'hFD); chk("blk_other_seg", seg, 8'h8E);
        run_to(129); chk("blk_on_an", an, 8'hFE); chk("blk_on_seg", seg, 8'hC0);
        run_to(161); chk("blk_off2_an", an, 8'hFF); chk("blk_off2_seg", seg, 8'hFF);
        run_to(165); chk("blk_other2_seg", seg, 8'hC0);

        // 4: decimal point on digit 7 with glyph A
        run_to(192); point = 8'h80; hexs = 32'hA000_0000;
        run_to(253); chk("dp_an7", an, 8'h7F); chk("dp_seg7", seg, 8'h08);

        // 5: display enable gating
        run_to(258); en = 1'b0;
        run_to(259); chk("en0_an", an, 8'hFF); chk("en0_seg", seg, 8'hFF);
        run_to(262); en = 1'b1;
        run_to(263); chk("en1_an", an, 8'hFD); chk("en1_seg", seg, 8'hC0);

        // 6: reset in the middle of digit 5
        run_to(277); rst = 1'b1;
        run_to(278); chk("midrst_an", an, 8'hFF); chk("midrst_seg", seg, 8'hFF);
        rst = 1'b0; e = 0;
        run_to(1);   chk("postrst_an", an, 8'hFE); chk("postrst_seg", seg, 8'hC0);
        run_to(29);  chk("postrst_an7", an, 8'h7F); chk("postrst_seg7", seg, 8'h40);

        // Random traffic against the model
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(7) == 0) hexs = $urandom;
            if ($urandom_range(5) == 0) blink = 8'($urandom);
            if ($urandom_range(5) == 0) point = 8'($urandom);
            en  = ($urandom_range(15) != 0);
            rst = ($urandom_range(199) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
